// File: rtl/cache_pkg.sv
// cache_pkg: shared constants, FSM state encoding and address helpers for the
// direct-mapped write-back data cache.
//   ADDR_W  - requester word-address width
//   DATA_W  - data word width
//   INDEX_W - index bits (one single-word line per index)
//   TAG_W   - tag bits kept per line
package cache_pkg;

    localparam int ADDR_W  = 30;
    localparam int DATA_W  = 32;
    localparam int INDEX_W = 10;
    localparam int TAG_W   = ADDR_W - INDEX_W;
    localparam int LINES   = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:INDEX_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[INDEX_W-1:0];
    endfunction

endpackage

// File: rtl/cache_store.sv
// cache_store: line storage for the cache. Tag and data arrays are plain
// memories with no reset; valid and dirty are flop vectors cleared by reset so
// the cache comes up empty.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   idx          - line index used for both the read and the write port
//   line_valid/line_dirty/line_tag/line_data - contents of line idx (async read)
//   line_we      - write tag/data, set valid, load dirty from we_dirty
//   we_tag, we_data, we_dirty - write-port payload
//   clr_dirty    - clear only the dirty bit of line idx (after a write-back)
module cache_store
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] idx,
    output logic               line_valid,
    output logic               line_dirty,
    output logic [TAG_W-1:0]   line_tag,
    output logic [DATA_W-1:0]  line_data,
    input  logic               line_we,
    input  logic [TAG_W-1:0]   we_tag,
    input  logic [DATA_W-1:0]  we_data,
    input  logic               we_dirty,
    input  logic               clr_dirty
);

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= we_dirty;
        end else if (clr_dirty) begin
            dirty_q[idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[idx]  <= we_tag;
            data_mem[idx] <= we_data;
        end
    end

    assign line_valid = valid_q[idx];
    assign line_dirty = dirty_q[idx];
    assign line_tag   = tag_mem[idx];
    assign line_data  = data_mem[idx];

endmodule

// File: rtl/cache_controller.sv
// cache_controller: direct-mapped, write-back, write-allocate cache with
// single-word lines between a word-addressed requester and a fixed-timing
// memory port (memory read data is valid in the cycle mem_addr is presented).
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   addr, wdata       - request word address and write data
//   wr, rd            - write / read request levels (wr has priority)
//   mem_data          - memory read data
//   mem_addr, mem_wr  - memory address and write strobe (write-back only)
//   cache_wb_data     - victim data during write-back
//   cache_r_hit       - read complete; cache_data carries the word
//   cache_data        - read data to requester
//
// Request handshake: rd and wr are levels that act as "valid"; the requester
// holds them together with addr/wdata unchanged until the transaction is
// accepted. A read is accepted in the cycle cache_r_hit is high (same cycle as
// the hit, combinationally). A write is accepted at the clock edge where the
// FSM sits in IDLE with wr high and the target line is writable (hit, invalid
// or clean); a held wr after that just rewrites the same line.
//
// The FSM state is kept in the named signal `state` (type state_t) so it can
// be probed or bound to by checkers.
module cache_controller
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wr,
    input  logic              rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic              cache_r_hit,
    output logic [DATA_W-1:0] cache_wb_data,
    output logic [DATA_W-1:0] cache_data
);

    state_t state;
    state_t state_next;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;

    logic               line_valid;
    logic               line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [DATA_W-1:0]  line_data;

    logic               line_we;
    logic [DATA_W-1:0]  we_data;
    logic               we_dirty;
    logic               clr_dirty;

    logic               hit;
    logic               victim_dirty;

    assign idx = addr_index(addr);
    assign tag = addr_tag(addr);

    cache_store u_store (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .line_tag   (line_tag),
        .line_data  (line_data),
        .line_we    (line_we),
        .we_tag     (tag),
        .we_data    (we_data),
        .we_dirty   (we_dirty),
        .clr_dirty  (clr_dirty)
    );

    assign hit          = line_valid && (line_tag == tag);
    // Only a valid dirty line must be written back before it is replaced.
    assign victim_dirty = line_valid && line_dirty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        line_we       = 1'b0;
        we_data       = wdata;
        we_dirty      = 1'b0;
        clr_dirty     = 1'b0;
        mem_addr      = '0;
        mem_wr        = 1'b0;
        cache_wb_data = '0;
        cache_r_hit   = 1'b0;
        cache_data    = '0;

        case (state)
            IDLE: begin
                if (wr) begin
                    if (hit || !victim_dirty) begin
                        // Write-allocate without a fill: a single-word line
                        // is fully overwritten, so the old contents are moot.
                        line_we  = 1'b1;
                        we_dirty = 1'b1;
                    end else begin
                        state_next = WB;
                    end
                end else if (rd) begin
                    if (hit) begin
                        cache_r_hit = 1'b1;
                        cache_data  = line_data;
                    end else if (victim_dirty) begin
                        state_next = WB;
                    end else begin
                        state_next = FILL;
                    end
                end
            end

            WB: begin
                // The victim's address is rebuilt from its stored tag and the
                // current index.
                mem_addr      = {line_tag, idx};
                mem_wr        = 1'b1;
                cache_wb_data = line_data;
                clr_dirty     = 1'b1;
                // A pending write finishes in IDLE now that the line is clean.
                state_next    = (rd && !wr) ? FILL : IDLE;
            end

            FILL: begin
                mem_addr   = addr;
                line_we    = 1'b1;
                we_data    = mem_data;
                we_dirty   = 1'b0;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed test of cache_controller. Stimulus tasks push
// the expected output events (write-back, fill, read hit) into exp_q; a monitor
// samples on the falling edge, and whenever the DUT shows any activity it pops
// one expected event and compares all outputs at once.
module tb_cache_controller;

    localparam int EW = 1 + 1 + 30 + 32 + 32;

    logic        clk;
    logic        rst;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_data;
    logic        wr;
    logic        rd;
    logic [29:0] mem_addr;
    logic        mem_wr;
    logic        cache_r_hit;
    logic [31:0] cache_wb_data;
    logic [31:0] cache_data;

    logic [EW-1:0] exp_q[$];
    int total;
    int bad;

    cache_controller dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .wdata         (wdata),
        .mem_data      (mem_data),
        .wr            (wr),
        .rd            (rd),
        .mem_addr      (mem_addr),
        .mem_wr        (mem_wr),
        .cache_r_hit   (cache_r_hit),
        .cache_wb_data (cache_wb_data),
        .cache_data    (cache_data)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [EW-1:0] ev(input logic h, input logic mw,
                                         input logic [29:0] ma,
                                         input logic [31:0] wb,
                                         input logic [31:0] cd);
        return {h, mw, ma, wb, cd};
    endfunction

    function automatic logic [EW-1:0] outs_now();
        return {cache_r_hit, mem_wr, mem_addr, cache_wb_data, cache_data};
    endfunction

    task automatic push_wb(input logic [29:0] a, input logic [31:0] d);
        exp_q.push_back(ev(1'b0, 1'b1, a, d, 32'h0));
    endtask

    task automatic push_fill(input logic [29:0] a);
        exp_q.push_back(ev(1'b0, 1'b0, a, 32'h0, 32'h0));
    endtask

    task automatic push_hit(input logic [31:0] d);
        exp_q.push_back(ev(1'b1, 1'b0, 30'h0, 32'h0, d));
    endtask

    task automatic check_idle_outs(input string name);
        total++;
        if (outs_now() != '0) begin
            bad++;
            $display("FAIL %s: outputs got %h want 0", name, outs_now());
        end
    endtask

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_write(input logic [29:0] a, input logic [31:0] d, input int cycles);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 wr = 1'b0;
    endtask

    // Holds rd until the first hit (bounded), checks the hit latency in cycles
    // counted from the request cycle, then keeps rd up for `hold` more cycles.
    task automatic do_read(input logic [29:0] a, input logic [31:0] md,
                           input int exp_lat, input int hold, input string name);
        int n;
        n        = 0;
        addr     = a;
        mem_data = md;
        rd       = 1'b1;
        @(negedge clk);
        while (!cache_r_hit && n < 20) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (!cache_r_hit || n != exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d (hit=%0b) want %0d", name, n, cache_r_hit, exp_lat);
        end
        repeat (hold) @(negedge clk);
        @(posedge clk);
        #1 rd = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst && (cache_r_hit || mem_wr || mem_addr != '0 ||
                    cache_wb_data != '0 || cache_data != '0)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got %h want no activity", outs_now());
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if (outs_now() != e) begin
                    bad++;
                    $display("FAIL bus_event: got %h want %h", outs_now(), e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        rd       = 1'b0;
        wr       = 1'b0;
        addr     = '0;
        wdata    = '0;
        mem_data = '0;

        #7 check_idle_outs("reset_outputs");
        #8 rst = 1'b1;
        @(posedge clk);
        #1;

        // Read of an empty cache: one fill cycle, then a hit.
        push_fill(30'd5);
        push_hit(32'h0000_0055);
        do_read(30'd5, 32'h0000_0055, 2, 0, "rd_after_reset");
        idle_cycles(2);

        // Write to an empty line, held 10 cycles: no memory traffic at all.
        do_write(30'd0, 32'h8765_4321, 10);
        idle_cycles(1);

        // Clean miss, then the hit is held for three more cycles.
        push_fill(30'd1);
        repeat (4) push_hit(32'h1234_5678);
        do_read(30'd1, 32'h1234_5678, 2, 3, "clean_miss");
        idle_cycles(1);

        // Conflict with dirty line 0: write-back, fill, hit.
        push_wb(30'd0, 32'h8765_4321);
        push_fill(30'd1024);
        push_hit(32'h1234_5678);
        do_read(30'd1024, 32'h1234_5678, 3, 0, "dirty_miss");
        idle_cycles(1);

        // Read hit right after a write: same-cycle data, no memory activity.
        do_write(30'd7, 32'hDEAD_BEEF, 1);
        push_hit(32'hDEAD_BEEF);
        do_read(30'd7, 32'h0, 0, 0, "rd_hit_after_wr");
        idle_cycles(1);

        // Write miss onto dirty line 3: write-back of addr 3, then the write lands.
        do_write(30'd3, 32'h0000_0033, 1);
        push_wb(30'd3, 32'h0000_0033);
        do_write(30'd1027, 32'hA5A5_A5A5, 3);
        push_hit(32'hA5A5_A5A5);
        do_read(30'd1027, 32'h0, 0, 0, "wr_miss_result");
        idle_cycles(1);

        // Read addr 3 evicts dirty 1027; reset lands in the middle of the WB.
        push_wb(30'd1027, 32'hA5A5_A5A5);
        addr = 30'd3;
        rd   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        rd  = 1'b0;
        #1 check_idle_outs("reset_mid_wb");
        @(posedge clk);
        #1 rst = 1'b1;
        idle_cycles(1);

        // After the abort the cache is empty: both lines miss clean.
        push_fill(30'd3);
        push_hit(32'h0000_0077);
        do_read(30'd3, 32'h0000_0077, 2, 0, "miss_after_abort");
        idle_cycles(1);
        push_fill(30'd7);
        push_hit(32'h0000_0070);
        do_read(30'd7, 32'h0000_0070, 2, 0, "line7_cleared");
        idle_cycles(3);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL exp_q_drained: got %0d pending want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
Name:
cache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache controller with single-word lines.
- Sits between a word-addressed requester (30-bit word address, 32-bit data) and a simple fixed-timing memory port.
- Serves read hits combinationally.
- Read misses: write back the dirty victim if needed, fill from memory, then hit.
- Writes: complete in the cache, marking the line dirty.

Parameters:
- ADDR_W, 30, word-address width.
- DATA_W, 32, data width.
- INDEX_W, 10, index bits (1024 lines); tag width = ADDR_W-INDEX_W = 20.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  30  request word address; index = addr[9:0], tag = addr[29:10].
- wdata  in  32  write data.
- mem_data  in  32  memory read data; valid in the same cycle mem_addr is presented.
- wr  in  1  write request (level; held until accepted).
- rd  in  1  read request (level; held until cache_r_hit).
- mem_addr  out  30  memory word address.
- mem_wr  out  1  memory write strobe during write-back.
- cache_r_hit  out  1  read data valid / read complete.
- cache_wb_data  out  32  victim data written back to memory.
- cache_data  out  32  read data to requester.

Behaviour:
- Storage per line:
  - valid and dirty bits, held in flop vectors and async-cleared by reset;
  - 20-bit tag and 32-bit data, not reset.
- hit = valid[idx] & (tag[idx]==addr tag).
- FSM states: IDLE, WB, FILL.
- Reset (rst=0): state=IDLE; all valid=0, dirty=0; all outputs 0. Reset mid-WB/FILL aborts to IDLE with the cache empty.
- IDLE transitions:
  - wr has priority over rd.
  - wr & (hit | !valid | !dirty): at the clock edge write data=wdata, tag, valid=1, dirty=1; stay IDLE. Write latency 1 cycle. A held wr rewrites harmlessly.
  - wr & miss & dirty victim: go to WB, then IDLE, where the write then completes.
  - rd & hit: cache_r_hit=1 and cache_data=line data, combinationally in the same cycle; no state change.
  - rd & miss & dirty victim: go to WB.
  - rd & miss & clean or invalid victim: go to FILL.
- WB (1 cycle):
  - mem_addr={victim tag, idx}, cache_wb_data=victim data, mem_wr=1.
  - At the edge: dirty[idx]=0. Next state is FILL if rd (and not wr), else IDLE.
- FILL (1 cycle):
  - mem_addr=addr, mem_wr=0.
  - At the edge: line data=mem_data, tag=addr tag, valid=1, dirty=0; go to IDLE.
  - The next cycle is a read hit.
- Read-miss latency:
  - clean victim: hit 2 cycles after request;
  - dirty victim: hit 3 cycles after request.
- Outputs outside their active states:
  - mem_addr=0, mem_wr=0, cache_wb_data=0;
  - cache_r_hit=0 unless IDLE & rd & !wr & hit;
  - cache_data=0 unless cache_r_hit.
- Neither rd nor wr: no state change.
- addr, wr and rd must stay stable until completion. A change during WB/FILL makes the fill follow the current addr; the requester must not do this.

Decomposition:
- Package cache_pkg:
  - ADDR_W, DATA_W, INDEX_W, TAG_W constants;
  - state enum {IDLE, WB, FILL};
  - tag/index extraction helpers.
- One natural sub-module, cache_store: the tag/data arrays plus valid/dirty vectors, with read by index and a write port (data, tag, set valid, set/clear dirty).

Test Plan:
- Reset: rst=0 for 15 time units → all outputs 0. Then rd=1, addr=5 → miss (cache_r_hit=0), FILL with mem_addr=5.
- Write to an empty line: rst=1, wr=1, addr=0, wdata=0x87654321 for 10 cycles → line 0 valid, dirty, data 0x87654321; mem_wr never asserted.
- Clean read miss: rd=1, addr=1, mem_data=0x12345678 → FILL cycle with mem_addr=1, then cache_r_hit=1, cache_data=0x12345678, held while rd stays high.
- Dirty conflict miss: rd=1, addr=1024 after the write above → WB cycle with mem_addr=0, cache_wb_data=0x87654321, mem_wr=1. Then FILL with mem_addr=1024. Then hit with cache_data=0x12345678.
- Read hit after write: wr addr=7 data=0xDEADBEEF, then rd addr=7 → cache_r_hit=1 the same cycle, cache_data=0xDEADBEEF, no memory activity.
- Write miss to a dirty line: dirty line 3 (tag 0), then wr addr=1027 data=0xA5A5A5A5 → WB of addr 3, then the line holds tag 1 with data 0xA5A5A5A5, dirty. Assert rst mid-WB → IDLE and a subsequent rd on addr 3 misses.
